// File: rtl/fetch_queue_if.sv
// Signal bundle between the fetch queue, instruction memory, PC control and decode.
// The master side is the fetch queue itself; the slave side is its surrounding pipeline.
interface fetch_queue_if;
   logic [15:0] imem_addr;
   logic        imem_req;
   logic [15:0] imem_data;
   logic        imem_valid;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        stall;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic [15:0] npc;
   logic        instr_valid;
   logic [3:0]  count;

   modport master (
      output imem_addr, imem_req, instr, instr_pc, npc, instr_valid, count,
      input  imem_data, imem_valid, redirect, redirect_pc, stall
   );

   modport slave (
      input  imem_addr, imem_req, instr, instr_pc, npc, instr_valid, count,
      output imem_data, imem_valid, redirect, redirect_pc, stall
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches and buffers returned
// instructions in a circular FIFO for decode, with flush on redirect.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic          clk,
   input  logic          reset,
   fetch_queue_if.master fq
);
   localparam int unsigned PTR_W     = $clog2(DEPTH);
   localparam logic [4:0]  DEPTH_LIM = 5'(DEPTH);

   if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be 2, 4 or 8");
   end

   typedef enum logic [1:0] {FETCH, FLUSH, HOLD} state_t;
   state_t state, state_next;

   logic [15:0]      q_instr [DEPTH];
   logic [15:0]      q_pc    [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [3:0]       count_q;
   logic [15:0]      fetch_pc;
   logic [15:0]      last_pc;
   logic             req_p1;
   logic [15:0]      req_pc_p1;

   logic             has_entry, pop, push, drop, issue_ok, req;
   logic [4:0]       demand;
   logic [15:0]      pc_out;

   // Issue/accept decisions for the current cycle
   assign has_entry = (count_q != 4'd0);
   assign drop      = (state == FLUSH);
   assign pop       = has_entry & ~fq.stall & ~fq.redirect;
   // Only a response to a request we actually issued may enter the queue
   assign push      = fq.imem_valid & req_p1 & ~drop & ~fq.redirect;
   assign demand    = {1'b0, count_q} + {4'b0000, req_p1} - {4'b0000, pop};
   assign issue_ok  = (demand < DEPTH_LIM);
   assign req       = ~fq.redirect & ~reset & issue_ok;

   always_comb begin
      state_next = state;
      unique case (state)
         FETCH, HOLD: begin
            if (fq.redirect)   state_next = req_p1 ? FLUSH : FETCH;
            else if (issue_ok) state_next = FETCH;
            else               state_next = HOLD;
         end
         FLUSH: begin
            if (fq.redirect)   state_next = req_p1 ? FLUSH : FETCH;
            else               state_next = FETCH;
         end
         default:              state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FETCH;
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count_q  <= 4'd0;
         req_p1   <= 1'b0;
         last_pc  <= RESET_PC;
      end else begin
         state  <= state_next;
         req_p1 <= req;
         if (fq.redirect) begin
            head     <= tail;
            count_q  <= 4'd0;
            fetch_pc <= fq.redirect_pc;
         end else begin
            if (req)  fetch_pc <= fetch_pc + 16'd1;
            if (push) tail     <= tail + 1'b1;
            if (pop)  head     <= head + 1'b1;
            count_q <= count_q + {3'b000, push} - {3'b000, pop};
         end
         if (has_entry) last_pc <= q_pc[head];
      end
   end

   // Request stage -> response stage: remember which address each response belongs to
   always_ff @(posedge clk) begin
      req_pc_p1 <= fetch_pc;
      if (push) begin
         q_instr[tail] <= fq.imem_data;
         q_pc[tail]    <= req_pc_p1;
      end
   end

   // Head-of-queue presentation to decode
   assign pc_out         = reset ? RESET_PC : (has_entry ? q_pc[head] : last_pc);
   assign fq.instr_valid = has_entry & ~reset;
   assign fq.instr       = fq.instr_valid ? q_instr[head] : 16'h0000;
   assign fq.instr_pc    = pc_out;
   assign fq.npc         = pc_out + 16'd1;
   assign fq.count       = count_q;
   assign fq.imem_addr   = fetch_pc;
   assign fq.imem_req    = req;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle table for streaming/stall/redirect plus
// hand-written sequences for long stall, address wrap and mid-run reset.
module tb_fetch_queue;
   logic clk = 1'b0;
   logic reset;
   logic inject;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   fetch_queue_if fq();

   fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk   (clk),
      .reset (reset),
      .fq    (fq)
   );

   // Memory answers one cycle after each request with addr + 0x1000; inject forces a stray response
   always_ff @(posedge clk) begin
      fq.imem_valid <= fq.imem_req | inject;
      fq.imem_data  <= fq.imem_addr + 16'h1000;
   end

   typedef struct packed {
      logic        stall;
      logic        redirect;
      logic [15:0] rpc;
      logic        req;
      logic [15:0] addr;
      logic        valid;
      logic [15:0] instr;
      logic [15:0] pc;
      logic [3:0]  cnt;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl [NV];

   function automatic vec_t mk(logic s, logic r, logic [15:0] rp, logic q, logic [15:0] a,
                               logic vl, logic [15:0] i, logic [15:0] p, logic [3:0] c);
      vec_t t;
      t.stall = s; t.redirect = r; t.rpc = rp; t.req = q; t.addr = a;
      t.valid = vl; t.instr = i; t.pc = p; t.cnt = c;
      return t;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      n_checks++;
      if (!(fq.count <= 4'd4)) begin
         n_fail++;
         $display("FAIL count_bound: got %0d expected <= 4", fq.count);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".req"},   {15'b0, fq.imem_req},    16'h0000);
      chk({tag, ".valid"}, {15'b0, fq.instr_valid}, 16'h0000);
      chk({tag, ".instr"}, fq.instr,                16'h0000);
      chk({tag, ".pc"},    fq.instr_pc,             16'h0000);
      chk({tag, ".npc"},   fq.npc,                  16'h0001);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] exp_pc;

      //            stall red rpc      req addr     vld instr    pc       cnt
      tbl[0]  = mk(0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 4'd0);
      tbl[1]  = mk(0, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 16'h0000, 4'd0);
      tbl[2]  = mk(0, 0, 16'h0000, 1, 16'h0002, 1, 16'h1000, 16'h0000, 4'd1);
      tbl[3]  = mk(0, 0, 16'h0000, 1, 16'h0003, 1, 16'h1001, 16'h0001, 4'd1);
      tbl[4]  = mk(1, 0, 16'h0000, 1, 16'h0004, 1, 16'h1002, 16'h0002, 4'd1);
      tbl[5]  = mk(1, 0, 16'h0000, 1, 16'h0005, 1, 16'h1002, 16'h0002, 4'd2);
      tbl[6]  = mk(1, 0, 16'h0000, 0, 16'h0006, 1, 16'h1002, 16'h0002, 4'd3);
      tbl[7]  = mk(1, 0, 16'h0000, 0, 16'h0006, 1, 16'h1002, 16'h0002, 4'd4);
      tbl[8]  = mk(0, 0, 16'h0000, 1, 16'h0006, 1, 16'h1002, 16'h0002, 4'd4);
      tbl[9]  = mk(0, 0, 16'h0000, 1, 16'h0007, 1, 16'h1003, 16'h0003, 4'd3);
      tbl[10] = mk(0, 1, 16'h0040, 0, 16'h0008, 1, 16'h1004, 16'h0004, 4'd3);
      tbl[11] = mk(0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0004, 4'd0);
      tbl[12] = mk(0, 0, 16'h0000, 1, 16'h0041, 0, 16'h0000, 16'h0004, 4'd0);
      tbl[13] = mk(0, 0, 16'h0000, 1, 16'h0042, 1, 16'h1040, 16'h0040, 4'd1);
      tbl[14] = mk(1, 1, 16'h0080, 0, 16'h0043, 1, 16'h1041, 16'h0041, 4'd1);
      tbl[15] = mk(0, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000, 16'h0041, 4'd0);
      tbl[16] = mk(0, 0, 16'h0000, 1, 16'h0081, 0, 16'h0000, 16'h0041, 4'd0);
      tbl[17] = mk(0, 0, 16'h0000, 1, 16'h0082, 1, 16'h1080, 16'h0080, 4'd1);

      reset = 1'b1; inject = 1'b0;
      fq.stall = 1'b0; fq.redirect = 1'b0; fq.redirect_pc = 16'h0000;
      @(posedge clk); #1;
      @(negedge clk);
      chk_reset_outputs("rst");
      @(posedge clk); #1;
      reset = 1'b0;

      for (int k = 0; k < NV; k++) begin
         fq.stall       = tbl[k].stall;
         fq.redirect    = tbl[k].redirect;
         fq.redirect_pc = tbl[k].rpc;
         @(negedge clk);
         chk($sformatf("v%0d.req", k),   {15'b0, fq.imem_req},    {15'b0, tbl[k].req});
         chk($sformatf("v%0d.addr", k),  fq.imem_addr,            tbl[k].addr);
         chk($sformatf("v%0d.valid", k), {15'b0, fq.instr_valid}, {15'b0, tbl[k].valid});
         chk($sformatf("v%0d.instr", k), fq.instr,                tbl[k].instr);
         chk($sformatf("v%0d.pc", k),    fq.instr_pc,             tbl[k].pc);
         chk($sformatf("v%0d.npc", k),   fq.npc,                  tbl[k].pc + 16'd1);
         chk($sformatf("v%0d.count", k), {12'b0, fq.count},       {12'b0, tbl[k].cnt});
         next_cycle();
      end
      fq.redirect = 1'b0; fq.stall = 1'b0;

      // Long stall: queue fills to 4, fetch stops, then drains contiguously
      fq.stall = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 9) begin
            chk("stall.count", {12'b0, fq.count},    16'd4);
            chk("stall.req",   {15'b0, fq.imem_req}, 16'd0);
            chk("stall.pc",    fq.instr_pc,          16'h0081);
         end
         next_cycle();
      end
      fq.stall = 1'b0;
      exp_pc = 16'h0081;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk($sformatf("drain%0d.valid", k), {15'b0, fq.instr_valid}, 16'd1);
         chk($sformatf("drain%0d.pc", k),    fq.instr_pc,             exp_pc);
         chk($sformatf("drain%0d.instr", k), fq.instr,                exp_pc + 16'h1000);
         exp_pc = exp_pc + 16'd1;
         next_cycle();
      end

      // Fetch address wrap at 0xFFFF
      fq.redirect = 1'b1; fq.redirect_pc = 16'hFFFE;
      next_cycle();
      fq.redirect = 1'b0;
      @(negedge clk);
      chk("wrap.addr0", fq.imem_addr, 16'hFFFE);
      chk("wrap.req0",  {15'b0, fq.imem_req}, 16'd1);
      next_cycle();
      @(negedge clk);
      chk("wrap.addr1", fq.imem_addr, 16'hFFFF);
      next_cycle();
      @(negedge clk);
      chk("wrap.addr2", fq.imem_addr, 16'h0000);
      chk("wrap.pc2",   fq.instr_pc,  16'hFFFE);
      next_cycle();
      @(negedge clk);
      chk("wrap.pc3",    fq.instr_pc, 16'hFFFF);
      chk("wrap.npc3",   fq.npc,      16'h0000);
      chk("wrap.instr3", fq.instr,    16'h0FFF);
      next_cycle();

      // Reset while full with a request issued; stray response after release
      fq.stall = 1'b1;
      for (int k = 0; k < 6; k++) next_cycle();
      fq.stall = 1'b0;
      @(negedge clk);
      chk("rfull.count", {12'b0, fq.count},    16'd4);
      chk("rfull.req",   {15'b0, fq.imem_req}, 16'd1);
      next_cycle();
      reset = 1'b1; inject = 1'b1;
      @(negedge clk);
      chk_reset_outputs("rmid");
      next_cycle();
      reset = 1'b0; inject = 1'b0;
      @(negedge clk);
      chk("rrel.count", {12'b0, fq.count},       16'd0);
      chk("rrel.valid", {15'b0, fq.instr_valid}, 16'd0);
      chk("rrel.addr",  fq.imem_addr,            16'h0000);
      chk("rrel.req",   {15'b0, fq.imem_req},    16'd1);
      next_cycle();
      @(negedge clk);
      chk("stray.count", {12'b0, fq.count},       16'd0);
      chk("stray.valid", {15'b0, fq.instr_valid}, 16'd0);
      next_cycle();
      @(negedge clk);
      chk("rstart.count", {12'b0, fq.count}, 16'd1);
      chk("rstart.instr", fq.instr,          16'h1000);
      chk("rstart.pc",    fq.instr_pc,       16'h0000);
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 4, giving the number of queue entries; only 2, 4 or 8 are legal.
REQ-002 The block SHALL have a parameter RESET_PC, default 16'h0000, giving the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous reset, active-high.
REQ-005 The block SHALL have port imem_addr, output, 16 bits: instruction memory word address.
REQ-006 The block SHALL have port imem_req, output, 1 bit: fetch request valid this cycle.
REQ-007 The block SHALL have port imem_data, input, 16 bits: instruction returned by memory.
REQ-008 The block SHALL have port imem_valid, input, 1 bit: imem_data valid; asserted exactly one cycle after each imem_req.
REQ-009 The block SHALL have port redirect, input, 1 bit: taken branch/jump/return from PC control.
REQ-010 The block SHALL have port redirect_pc, input, 16 bits: new fetch address, sampled when redirect=1.
REQ-011 The block SHALL have port stall, input, 1 bit: from hazard detection; decode not accepting.
REQ-012 The block SHALL have port instr, output, 16 bits: head instruction to decode.
REQ-013 The block SHALL have port instr_pc, output, 16 bits: address of instr.
REQ-014 The block SHALL have port npc, output, 16 bits: instr_pc+1, mod 2^16.
REQ-015 The block SHALL have port instr_valid, output, 1 bit: head entry valid.
REQ-016 The block SHALL have port count, output, 4 bits: occupied entries, 0..DEPTH.

Function
REQ-017 The queue SHALL be a circular FIFO of DEPTH entries {instr, pc}, with head/tail pointers wrapping modulo DEPTH.
REQ-018 A pop SHALL occur in a cycle when instr_valid=1, stall=0 and redirect=0.
REQ-019 A push SHALL occur in a cycle when imem_valid=1, drop=0 and redirect=0; the entry SHALL be {imem_data, address of the matching request}.
REQ-020 Let inflight = (imem_req was 1 in the previous cycle).
REQ-021 imem_req SHALL be 1 iff redirect=0, reset=0 and count + inflight - pop < DEPTH (pop is the current-cycle pop).
REQ-022 imem_addr SHALL equal fetch_pc, and fetch_pc SHALL increment by 1 (wrapping 16'hFFFF -> 16'h0000) on every cycle with imem_req=1.
REQ-023 Overflow SHALL be impossible: a push into a full queue is a design error, and a bench assertion SHALL check count <= DEPTH.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged, including at count=DEPTH, when the pop frees the slot, and at count=1.
REQ-025 The push path SHALL have no bypass: a pushed word SHALL be visible on instr no earlier than the following cycle.
REQ-026 When count=0: instr_valid=0, instr=16'h0000 (NOP), and instr_pc/npc SHALL hold their last values.
REQ-027 A redirect SHALL set head=tail and count=0, load fetch_pc<=redirect_pc, and suppress both pop and push in that cycle.
REQ-028 A redirect SHALL set drop<=inflight at the next edge, so that the response arriving in the cycle after the redirect is discarded; drop SHALL then clear.
REQ-029 Redirect SHALL take priority over stall, pop and push when they coincide.
REQ-030 Back-to-back redirects SHALL each take effect; the last one wins fetch_pc.
REQ-031 The control FSM SHALL have three states:
- FETCH: normal operation.
- FLUSH: one cycle, entered on redirect with inflight=1; imem_req is allowed; imem_valid is ignored; returns to FETCH.
- HOLD: entered when the issue condition of REQ-021 is false without redirect; returns to FETCH when the condition is true.
REQ-032 Steady-state throughput SHALL be one instruction per cycle when stall=0.
REQ-033 Latency SHALL be: request in cycle N, push at the end of N+1, instr_valid in N+2.

Reset
REQ-034 With reset=1 at a clock edge, the block SHALL set fetch_pc=RESET_PC, head=tail=0, count=0, drop=0, state=FETCH, and clear inflight history.
REQ-035 While reset=1, outputs SHALL be imem_req=0, instr_valid=0, instr=16'h0000, instr_pc=RESET_PC, npc=RESET_PC+1.
REQ-036 Reset asserted mid-operation SHALL discard all entries, and any imem_valid in the cycle after reset deassertion SHALL be ignored unless a request was issued.

Verification
REQ-037 Reset then release at cycle 0, memory returning addr+16'h1000, stall=0 -> imem_addr 0,1,2...; instr_valid first at cycle 2 with instr=16'h1000, instr_pc=0; then one instruction per cycle.
REQ-038 stall=1 held for 10 cycles -> count rises to 4 and stays; imem_req=0 once count+inflight=4; no entry lost; on release, instr sequence is contiguous.
REQ-039 Redirect to 16'h0040 while count=3 and a request is inflight -> next cycle count=0 and instr_valid=0; the in-flight word is dropped; the next instr is from pc 16'h0040.
REQ-040 Redirect asserted in the same cycle as stall=1 and a pending push -> flush wins; no push occurs; fetch resumes at redirect_pc.
REQ-041 fetch_pc reaches 16'hFFFF -> the next request address is 16'h0000; npc for pc 16'hFFFF is 16'h0000.
REQ-042 Reset asserted with count=4 and a request inflight -> the following cycle has count=0 and instr_valid=0; the stray imem_valid is ignored; fetch restarts at RESET_PC.
